// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Fetch stage feeding the decode/control unit. Owns the PC,
//                issues in-order word reads to instruction memory over a
//                valid/ready request channel, accepts in-order responses,
//                buffers them in a small queue and presents {Instr, instr_pc}
//                to decode with a valid/ready handshake. A redirect pulse
//                from decode (PCsrc) flushes the queue, discards responses
//                still in flight and restarts fetching at the new target.
//
//  Parameters  : RESET_PC  - PC loaded on reset (bits [1:0] must be 0)
//                QDEPTH    - instruction queue entries (power of 2, >= 2)
//                MAX_OUTST - max imem requests in flight
//
//  Ports       : clk, rst_n (async assert, active low)
//                imem_req_valid/imem_req_ready/imem_addr  - fetch request
//                imem_rsp_valid/imem_rdata                - in-order response
//                redirect/redirect_target                 - PC redirect
//                instr_valid/instr_ready/Instr/instr_pc   - to decode
//
//  Build macro : FETCH_BYPASS_EN - when defined, a response arriving while
//                the queue is empty and nothing is being dropped is forwarded
//                combinationally to decode in the same cycle (stored only if
//                decode stalls). When undefined, every word goes through the
//                queue and the decode-side outputs come from registers.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          QDEPTH    = 2,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] instr_pc
);

    localparam int          c_PW  = $clog2(QDEPTH);
    localparam int          c_CW  = $clog2(QDEPTH) + 1;
    localparam int          c_OW  = $clog2(MAX_OUTST + 1);
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    // Sticky state
    logic [31:0]     r_fetch_pc;   // address of the next request to issue
    logic [31:0]     r_rsp_pc;     // PC belonging to the next kept response
    logic [c_OW-1:0] r_outst;      // requests accepted, response pending
    logic [c_OW-1:0] r_drop;       // pending responses that are stale
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;
    logic [31:0]     r_q_instr [QDEPTH];
    logic [31:0]     r_q_pc    [QDEPTH];

    logic [31:0]     w_target;
    logic [31:0]     w_occupancy;
    logic            w_q_empty;
    logic            w_accept;
    logic            w_keep;
    logic            w_push;
    logic            w_pop;
    logic [c_OW-1:0] w_outst_next;
`ifdef FETCH_BYPASS_EN
    logic            w_bypass;
`endif

    always_comb begin
        w_target    = redirect_target & 32'hFFFF_FFFC;
        // Every in-flight request already owns a queue slot, so a response
        // can always be pushed without checking for space.
        w_occupancy = 32'(r_count) + 32'(r_outst);
        w_q_empty   = (r_count == '0);

        imem_req_valid = rst_n && !redirect
                      && (32'(r_outst) < 32'(MAX_OUTST))
                      && (w_occupancy < 32'(QDEPTH));
        imem_addr      = r_fetch_pc;

        w_accept     = imem_req_valid && imem_req_ready;
        // A response coinciding with a redirect is stale and never kept.
        w_keep       = rst_n && imem_rsp_valid && !redirect && (r_drop == '0);
        w_pop        = !w_q_empty && instr_ready;
        w_outst_next = r_outst + c_OW'(w_accept) - c_OW'(imem_rsp_valid);

`ifdef FETCH_BYPASS_EN
        w_bypass    = w_keep && w_q_empty;
        w_push      = w_keep && !(w_bypass && instr_ready);
        instr_valid = !w_q_empty || w_bypass;
        Instr       = w_bypass ? imem_rdata : r_q_instr[r_rd_ptr];
        instr_pc    = w_bypass ? r_rsp_pc   : r_q_pc[r_rd_ptr];
`else
        w_push      = w_keep;
        instr_valid = !w_q_empty;
        Instr       = r_q_instr[r_rd_ptr];
        instr_pc    = r_q_pc[r_rd_ptr];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            // Head entry doubles as the idle output, so it resets to a NOP.
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_instr[i] <= c_NOP;
                r_q_pc[i]    <= RESET_PC;
            end
        end else begin
            r_outst <= w_outst_next;
            if (redirect) begin
                // Everything still in flight after this cycle's updates is
                // stale, including anything already marked for dropping.
                r_drop     <= w_outst_next;
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (imem_rsp_valid) begin
                    if (r_drop != '0) begin
                        r_drop <= r_drop - c_OW'(1);
                    end else begin
                        r_rsp_pc <= r_rsp_pc + 32'd4;
                    end
                end
                if (w_push) begin
                    r_q_instr[r_wr_ptr] <= imem_rdata;
                    r_q_pc[r_wr_ptr]    <= r_rsp_pc;
                    r_wr_ptr            <= r_wr_ptr + c_PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PW'(1);
                end
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. An in-order imem model
//                answers requests (data = address ^ data_xor); a queue-based
//                reference model predicts every DUT output each cycle from
//                the fetch-stage rules, and directed scenarios pin the model
//                with hand-computed literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
    localparam int          c_QDEPTH    = 2;
    localparam int          c_MAX_OUTST = 2;
    localparam logic [31:0] c_NONE      = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] Instr;
    logic [31:0] instr_pc;

    instr_fetch #(
        .RESET_PC  (c_RESET_PC),
        .QDEPTH    (c_QDEPTH),
        .MAX_OUTST (c_MAX_OUTST)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .Instr           (Instr),
        .instr_pc        (instr_pc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;      // cycles since last reset release
    int cyc_total = 0;
    int first_valid_cyc = -1;
    logic [31:0] data_xor = 32'h0;

    // Reference model state
    logic [31:0] inflight[$];           // addresses accepted, awaiting response
    logic [31:0] mq_instr[$];
    logic [31:0] mq_pc[$];
    logic [31:0] m_fetch_pc, m_rsp_pc, m_next_pc;
    int          m_drop;

    // Observation logs used by the directed literal checks
    logic [31:0] acc_log[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_instr[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_total);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : c_NONE;
    endfunction

    task automatic clear_logs();
        acc_log.delete();
        dlv_pc.delete();
        dlv_instr.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        instr_ready = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; redirect = 1'b0;
        #1;
        check32("rst_req_valid",   32'(imem_req_valid), 32'd0);
        check32("rst_instr_valid", 32'(instr_valid),    32'd0);
        check32("rst_instr",       Instr,               32'h0000_0013);
        check32("rst_instr_pc",    instr_pc,            c_RESET_PC);
        inflight.delete(); mq_instr.delete(); mq_pc.delete();
        m_fetch_pc = c_RESET_PC; m_rsp_pc = c_RESET_PC; m_next_pc = c_RESET_PC;
        m_drop = 0;
        cyc_cnt = 0;
        first_valid_cyc = -1;
        clear_logs();
        repeat (2) @(negedge clk);
    endtask

    // One clock cycle: drive inputs at the falling edge, compare the DUT
    // against the model, then advance the model to the next rising edge.
    task automatic cycle(input bit rdy, input bit mrdy, input bit rsp_en,
                         input bit redir, input logic [31:0] tgt);
        logic [31:0] a, exp_i, exp_p;
        bit exp_rv, exp_iv, keep, byp, acc, pop;
        @(negedge clk);
        rst_n           = 1'b1;
        instr_ready     = rdy;
        imem_req_ready  = mrdy;
        redirect        = redir;
        redirect_target = tgt;
        imem_rsp_valid  = rsp_en && (inflight.size() > 0);
        a               = imem_rsp_valid ? inflight[0] : 32'h0;
        imem_rdata      = imem_rsp_valid ? (a ^ data_xor) : $urandom;
        #1;
        exp_rv = !redir && (inflight.size() < c_MAX_OUTST)
              && ((mq_pc.size() + inflight.size()) < c_QDEPTH);
        keep   = imem_rsp_valid && !redir && (m_drop == 0);
        byp    = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp    = keep && (mq_pc.size() == 0);
`endif
        exp_iv = (mq_pc.size() != 0) || byp;
        exp_i  = byp ? (a ^ data_xor) : qget(mq_instr, 0);
        exp_p  = byp ? m_rsp_pc       : qget(mq_pc, 0);

        check32("imem_req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check32("imem_addr", imem_addr, m_fetch_pc);
        check32("instr_valid", 32'(instr_valid), 32'(exp_iv));
        if (exp_iv) begin
            check32("Instr",      Instr,    exp_i);
            check32("instr_pc",   instr_pc, exp_p);
            check32("pc_seq",     instr_pc, m_next_pc);
            check32("instr_data", Instr,    instr_pc ^ data_xor);
        end

        if (imem_req_valid && mrdy) acc_log.push_back(imem_addr);
        if (instr_valid && rdy) begin
            dlv_pc.push_back(instr_pc);
            dlv_instr.push_back(Instr);
        end
        if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc_cnt;

        acc = exp_rv && mrdy;
        pop = exp_iv && rdy;
        if (pop) m_next_pc = m_next_pc + 32'd4;
        if (imem_rsp_valid) void'(inflight.pop_front());
        if (acc) inflight.push_back(m_fetch_pc);
        if (redir) begin
            mq_instr.delete(); mq_pc.delete();
            m_drop     = inflight.size();
            m_fetch_pc = {tgt[31:2], 2'b00};
            m_rsp_pc   = m_fetch_pc;
            m_next_pc  = m_fetch_pc;
        end else begin
            if (acc) m_fetch_pc = m_fetch_pc + 32'd4;
            if (pop && !byp) begin
                void'(mq_instr.pop_front());
                void'(mq_pc.pop_front());
            end
            if (imem_rsp_valid) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    if (!(byp && rdy)) begin
                        mq_instr.push_back(a ^ data_xor);
                        mq_pc.push_back(m_rsp_pc);
                    end
                    m_rsp_pc = m_rsp_pc + 32'd4;
                end
            end
        end
        cyc_cnt++;
        cyc_total++;
    endtask

    initial begin
        int n_acc;
        int exp_lat;
        logic [31:0] tgt;
`ifdef FETCH_BYPASS_EN
        exp_lat = 1;
`else
        exp_lat = 2;
`endif
        // 1: zero-wait imem, addr-as-data, decode always ready
        do_reset();
        repeat (8) cycle(1, 1, 1, 0, 32'h0);
        check32("latency_first_valid", 32'(first_valid_cyc), 32'(exp_lat));
        for (int i = 0; i < 3; i++) begin
            check32("t1_instr", qget(dlv_instr, i), 32'(4 * i));
            check32("t1_pc",    qget(dlv_pc, i),    32'(4 * i));
        end

        // 2: decode stalled for 10 cycles
        do_reset();
        repeat (10) cycle(0, 1, 1, 0, 32'h0);
        n_acc = acc_log.size();
        check32("t2_accept_bound", 32'(n_acc <= c_QDEPTH), 32'd1);
        repeat (6) cycle(1, 1, 1, 0, 32'h0);
        check32("t2_first",  qget(dlv_instr, 0), 32'h0);
        check32("t2_second", qget(dlv_instr, 1), 32'h4);
        check32("t2_third",  qget(dlv_pc, 2),    32'h8);

        // 3: redirect with two requests in flight
        do_reset();
        repeat (2) cycle(1, 1, 0, 0, 32'h0);
        clear_logs();
        cycle(1, 1, 0, 1, 32'h0000_0103);
        repeat (8) cycle(1, 1, 1, 0, 32'h0);
        check32("t3_next_addr", qget(acc_log, 0), 32'h0000_0100);
        check32("t3_next_pc",   qget(dlv_pc, 0),  32'h0000_0100);

        // 4: redirect coinciding with a response and a pop
        do_reset();
        cycle(0, 1, 1, 0, 32'h0);
        cycle(0, 1, 1, 0, 32'h0);
        cycle(0, 1, 0, 0, 32'h0);
        clear_logs();
        cycle(1, 1, 1, 1, 32'h0000_0200);
        cycle(0, 0, 0, 0, 32'h0);
        check32("t4_empty_after", 32'(instr_valid), 32'd0);
        check32("t4_pop_count",   32'(dlv_pc.size()), 32'd1);
        repeat (6) cycle(1, 1, 1, 0, 32'h0);
        check32("t4_popped_pc", qget(dlv_pc, 0), 32'h0);
        check32("t4_next_pc",   qget(dlv_pc, 1), 32'h0000_0200);

        // 5: imem back-pressure holds the request
        do_reset();
        repeat (2) cycle(1, 1, 1, 0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 1, 0, 32'h0);
            if (i >= 2 && i <= 6) begin
                check32("t5_req_held", 32'(imem_req_valid), 32'd1);
                check32("t5_addr_held", imem_addr, 32'h8);
            end
        end

        // 6: PC wrap at the top of the address space, then reset mid-burst
        repeat (3) cycle(1, 1, 1, 0, 32'h0);
        clear_logs();
        cycle(1, 1, 1, 1, 32'hFFFF_FFF8);
        repeat (8) cycle(1, 1, 1, 0, 32'h0);
        check32("t6_wrap_a", qget(acc_log, 0), 32'hFFFF_FFF8);
        check32("t6_wrap_b", qget(acc_log, 1), 32'hFFFF_FFFC);
        check32("t6_wrap_c", qget(acc_log, 2), 32'h0000_0000);
        cycle(1, 1, 1, 0, 32'h0);
        do_reset();

        // Randomised traffic against the model
        data_xor = 32'h5A5A_C3C3;
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: tgt = 32'($urandom_range(0, 1023));
            endcase
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                      $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0, tgt);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
